fetch_unit: RTL

- Instruction-fetch stage that owns the PC and drives the instruction memory's address and stall inputs.
- Consumes the memory's 2-bit status/data response and buffers completed fetches in a small FIFO.
- Presents {pc, inst} to decode through a valid/ready handshake.
- Handles branch/jump redirects by aborting the in-flight access and flushing buffered instructions.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_queue.sv | 84 ++++++++
 rtl/fetch_unit.sv | 86 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage:
//               instruction-memory response encoding, queue entry layout and
//               the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   // Instruction-memory response status. 2'b11 is illegal and has no name.
   typedef enum logic [1:0] {
      IMEM_IDLE  = 2'b00,
      IMEM_BUSY  = 2'b01,
      IMEM_VALID = 2'b10
   } imem_status_e;

   // One buffered fetch: the address it was fetched from and the word.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

   // Redirect targets are word aligned by dropping the two low bits.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle of the fetch stage's bus signals.
//               Instruction memory : imem_addr, imem_stall (to memory),
//                                    imem_r_data, imem_r_data_status (from).
//               Execute redirect   : redirect_valid, redirect_pc.
//               Decode handshake   : inst_valid, inst, inst_pc (to decode),
//                                    dec_ready (from decode).
//               master = fetch-unit side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
   logic [31:0] imem_addr;
   logic        imem_stall;
   logic [31:0] imem_r_data;
   logic [1:0]  imem_r_data_status;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        dec_ready;

   modport master (
      output imem_addr, imem_stall, inst_valid, inst, inst_pc,
      input  imem_r_data, imem_r_data_status, redirect_valid, redirect_pc,
             dec_ready
   );

   modport slave (
      input  imem_addr, imem_stall, inst_valid, inst, inst_pc,
      output imem_r_data, imem_r_data_status, redirect_valid, redirect_pc,
             dec_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular FIFO of fetch_entry_t with synchronous flush.
//               The head entry is presented combinationally from storage.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_flush        - drop all entries (pointers/count to zero)
//               i_push, i_push_data - write one entry at the write pointer
//               i_pop          - retire the head entry
//               o_head         - entry at the read pointer
//               o_count        - number of valid entries
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  wire logic                       clk,
   input  wire logic                       rst,
   input  wire logic                       i_flush,
   input  wire logic                       i_push,
   input  wire fetch_entry_t               i_push_data,
   input  wire logic                       i_pop,
   output fetch_entry_t                    o_head,
   output logic [$clog2(DEPTH):0]          o_count,
   output logic                            o_full,
   output logic                            o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

   fetch_entry_t       r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_push;
   logic               w_pop;

   // Pushing into a full queue or popping an empty one is dropped here so
   // the occupancy can never leave [0, DEPTH].
   assign w_push = i_push && (r_count != c_DEPTH_CNT);
   assign w_pop  = i_pop  && (r_count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         // Storage is left as is; only occupancy is discarded.
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;   // DEPTH is a power of two
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == c_DEPTH_CNT);
   assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the fetch PC, drives the
//               instruction memory address/stall, buffers completed fetches
//               in a small queue and hands {pc, inst} to decode via a
//               valid/ready handshake. Redirects abort the in-flight access
//               and flush the queue.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - fetch_unit_if.master (memory, redirect, decode)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int          QUEUE_DEPTH = 2
) (
   input  wire logic      clk,
   input  wire logic      rst,
   fetch_unit_if.master   bus
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CNT_W-1:0] c_FULL_COUNT = CNT_W'(QUEUE_DEPTH);

   logic [31:0]        r_fetch_pc;

   logic               w_resp_valid;
   logic               w_push;
   logic               w_pop;
   logic               w_q_full;
   logic               w_q_empty;
   logic [CNT_W-1:0]   w_q_count;
   fetch_entry_t       w_push_data;
   fetch_entry_t       w_head;

   assign w_resp_valid = (bus.imem_r_data_status == IMEM_VALID);

   // A response arriving in a redirect cycle belongs to the old path and is
   // dropped; illegal status 2'b11 never matches IMEM_VALID.
   assign w_push = w_resp_valid && !bus.redirect_valid && !w_q_full;
   assign w_pop  = !w_q_empty && bus.dec_ready && !bus.redirect_valid;

   assign w_push_data.pc   = r_fetch_pc;
   assign w_push_data.inst = bus.imem_r_data;

   // Stall on full uses the registered count and ignores a same-cycle pop:
   // the memory always needs a busy cycle before it can complete again, so
   // a full queue can never see a completed response.
   assign bus.imem_stall = bus.redirect_valid || (w_q_count == c_FULL_COUNT);

   // The address only moves on an accepted response or a redirect, which
   // keeps it stable for the whole memory access.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
      end else if (bus.redirect_valid) begin
         r_fetch_pc <= align_pc(bus.redirect_pc);
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   fetch_queue #(
      .DEPTH        (QUEUE_DEPTH)
   ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (bus.redirect_valid),
      .i_push       (w_push),
      .i_push_data  (w_push_data),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_count      (w_q_count),
      .o_full       (w_q_full),
      .o_empty      (w_q_empty)
   );

   assign bus.imem_addr  = r_fetch_pc;
   assign bus.inst_valid = !w_q_empty;
   assign bus.inst       = w_head.inst;
   assign bus.inst_pc    = w_head.pc;

endmodule
`default_nettype wire
